move_sequencer: RTL

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/rapcores_pkg.sv | 22 ++
 rtl/move_sequencer_if.sv | 37 +++
 rtl/move_fifo.sv | 55 +++++
 rtl/move_sequencer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/rapcores_pkg.sv
// Shared types for the rapcores motion blocks: the queued move record and
// the sequencer state encoding.
package rapcores_pkg;

    localparam int MOVE_W_DEFAULT = 64;

    // Fields are sized for the widest supported move; narrower builds
    // zero/sign-extend into them.
    typedef struct packed {
        logic                      dir;
        logic [MOVE_W_DEFAULT-1:0] duration;
        logic [MOVE_W_DEFAULT-1:0] increment;
        logic [MOVE_W_DEFAULT-1:0] incinc;
    } move_cmd_t;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_RUN   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/move_sequencer_if.sv
// Host command channel and step-generator channel of the move sequencer.
// slave is the sequencer side, master is the host/generator side.
interface move_sequencer_if
    import rapcores_pkg::*;
#(
    parameter int MOVE_W = MOVE_W_DEFAULT
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [MOVE_W-1:0] cmd_duration;
    logic [MOVE_W-1:0] cmd_increment;
    logic [MOVE_W-1:0] cmd_incinc;

    logic              gen_start;
    logic              gen_dir;
    logic [MOVE_W-1:0] gen_duration;
    logic [MOVE_W-1:0] gen_increment;
    logic [MOVE_W-1:0] gen_incinc;
    logic              gen_done;

    modport slave (
        input  cmd_valid, cmd_dir, cmd_duration, cmd_increment, cmd_incinc,
        output cmd_ready,
        output gen_start, gen_dir, gen_duration, gen_increment, gen_incinc,
        input  gen_done
    );

    modport master (
        output cmd_valid, cmd_dir, cmd_duration, cmd_increment, cmd_incinc,
        input  cmd_ready,
        input  gen_start, gen_dir, gen_duration, gen_increment, gen_incinc,
        output gen_done
    );

endinterface

// File: rtl/move_fifo.sv
// Synchronous DEPTH-entry queue of move_cmd_t with first-word fall-through head.
module move_fifo
    import rapcores_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         push,
    input  move_cmd_t                    push_data,
    input  logic                         pop,
    output move_cmd_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    move_cmd_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLK) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (resetn && !flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/move_sequencer.sv
// Queues host move commands and launches them one at a time on the step generator.
// Optional MOVE_SEQUENCER_ABORT_EN adds abort input and gen_abort output.
module move_sequencer
    import rapcores_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int MOVE_W = MOVE_W_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         resetn,
    move_sequencer_if.slave              bus,
    output logic [$clog2(DEPTH+1)-1:0]   fill,
    output logic                         idle,
    output logic                         underrun,
    input  logic                         clr_underrun,
    output logic [31:0]                  moves_done
`ifdef MOVE_SEQUENCER_ABORT_EN
    ,
    input  logic                         abort,
    output logic                         gen_abort
`endif
);

    seq_state_t state;
    seq_state_t state_nxt;
    move_cmd_t  cmd_in;
    move_cmd_t  head;
    logic       active_q;
    logic       done_q;
    logic       have_next_q;
    logic       abort_req;
    logic       push;
    logic       pop;
    logic       done_evt;
    logic       fifo_full;
    logic       fifo_empty;

`ifdef MOVE_SEQUENCER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // active_q keeps cmd_ready low while in reset without looking at inputs.
    assign bus.cmd_ready = active_q && !fifo_full;
    assign push          = bus.cmd_valid && bus.cmd_ready && !abort_req;
    assign pop           = (state == SEQ_ISSUE);
    assign bus.gen_start = (state == SEQ_ISSUE);
    assign idle          = (state == SEQ_IDLE) && fifo_empty;
    assign done_evt      = bus.gen_done && (state == SEQ_RUN) && !done_q && !abort_req;

    always_comb begin
        cmd_in           = '0;
        cmd_in.dir       = bus.cmd_dir;
        cmd_in.duration  = MOVE_W_DEFAULT'(bus.cmd_duration);
        cmd_in.increment = MOVE_W_DEFAULT'($signed(bus.cmd_increment));
        cmd_in.incinc    = MOVE_W_DEFAULT'($signed(bus.cmd_incinc));
    end

    move_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .resetn    (resetn),
        .flush     (abort_req),
        .push      (push),
        .push_data (cmd_in),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fill)
    );

    // gen_done is registered first so both launch paths reach gen_start two cycles later.
    always_comb begin
        state_nxt = state;
        case (state)
            SEQ_IDLE:  if (!fifo_empty) state_nxt = SEQ_ISSUE;
            SEQ_ISSUE: state_nxt = SEQ_RUN;
            SEQ_RUN:   if (done_q) state_nxt = have_next_q ? SEQ_ISSUE : SEQ_IDLE;
            default:   state_nxt = SEQ_IDLE;
        endcase
        if (abort_req) state_nxt = SEQ_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state       <= SEQ_IDLE;
            active_q    <= 1'b0;
            done_q      <= 1'b0;
            have_next_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            active_q    <= 1'b1;
            done_q      <= done_evt;
            have_next_q <= !fifo_empty;
        end
    end

    // Parameters are captured from the head as ISSUE is entered, so they are
    // valid alongside gen_start and hold until the next launch.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            bus.gen_dir       <= 1'b0;
            bus.gen_duration  <= '0;
            bus.gen_increment <= '0;
            bus.gen_incinc    <= '0;
        end else if (state_nxt == SEQ_ISSUE) begin
            bus.gen_dir       <= head.dir;
            bus.gen_duration  <= head.duration[MOVE_W-1:0];
            bus.gen_increment <= head.increment[MOVE_W-1:0];
            bus.gen_incinc    <= head.incinc[MOVE_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            moves_done <= '0;
            underrun   <= 1'b0;
        end else begin
            if (done_evt) moves_done <= moves_done + 32'd1;
            if (done_evt && fifo_empty) underrun <= 1'b1;
            else if (clr_underrun)      underrun <= 1'b0;
        end
    end

`ifdef MOVE_SEQUENCER_ABORT_EN
    always_ff @(posedge CLK) begin
        if (!resetn) gen_abort <= 1'b0;
        else         gen_abort <= abort_req && ((state == SEQ_RUN) || (state == SEQ_ISSUE));
    end
`endif

endmodule
